// File: rtl/pager_tlb_pkg.sv
// pager_tlb_pkg
//   Shared definitions for the page-translation table and the page-fail
//   dispatch that consumes its flags. Bit positions use the PDP-10 word
//   numbering [0:35], where bit 0 is the MSB and bit 35 the LSB.
//   No ports; imported with import pager_tlb_pkg::*.
package pager_tlb_pkg;

    localparam int PAGE_AW_DEF = 9;
    localparam int PPN_W_DEF   = 11;

    // pageFLAGS[0:3] field positions
    localparam int FLAG_VALID     = 0;
    localparam int FLAG_WRITEABLE = 1;
    localparam int FLAG_CACHEABLE = 2;
    localparam int FLAG_USER      = 3;

    // Flag layout presented whenever translation is bypassed: valid and
    // writeable, so the dispatch stage never raises a fault for unmapped
    // accesses.
    localparam logic [0:3] FLAGS_UNPAGED = 4'b1100;

    // Page-write data positions in dp[0:35]; the PPN occupies the low
    // PPN_W bits ending at bit 35.
    localparam int DP_VALID     = 18;
    localparam int DP_WRITEABLE = 21;
    localparam int DP_CACHEABLE = 22;
    localparam int DP_USER      = 23;
    localparam int DP_LSB       = 35;

    // VMA fields: physical-reference flag, and the last bit of the page
    // index / physical page address field.
    localparam int VMA_PHYS     = 8;
    localparam int VMA_PAGE_LSB = 26;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/pager_tlb_ram.sv
// pager_tlb_ram
//   Simple dual-port synchronous RAM, one write port and one read port.
//   A read of the address being written in the same cycle returns the new
//   data. The read register has a synchronous active-low clear so the
//   translation outputs come up as zero after reset.
// Ports:
//   clk, rst        clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read enable / address; rdata is valid the cycle after re
module pager_tlb_ram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pager_tlb.sv
// pager_tlb
//   Page-translation table feeding the page-fail dispatch. Translates the
//   VMA page index to a physical page number plus four page flags, one
//   clken-cycle after the VMA is presented, and runs the invalidate-all
//   sweep that the microcode starts after paging is reconfigured (and that
//   runs automatically after every reset).
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | table usable; page writes accepted
//   ST_SWEEP | clearing one entry per clken cycle; writes dropped,
//            | valid flag forced low on paged lookups
//
// Ports:
//   clk, rst (sync, active-low), clken (CPU clock enable)
//   dp          page-write data source
//   vmaREG      VMA; [18:26] page index, [16:26] unpaged address, [8] phys
//   pageENABLE  paging enabled
//   pageWRITE   write table entry from dp
//   pageSWEEP   start/restart the invalidate-all sweep
//   pageFLAGS   [0:3] valid, writeable, cacheable, user
//   pageADDR    physical page number
//   sweepBUSY   sweep in progress
module pager_tlb
    import pager_tlb_pkg::*;
#(
    parameter int PAGE_AW = PAGE_AW_DEF,
    parameter int PPN_W   = PPN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic [0:35]      dp,
    input  logic [0:35]      vmaREG,
    input  logic             pageENABLE,
    input  logic             pageWRITE,
    input  logic             pageSWEEP,
    output logic [0:3]       pageFLAGS,
    output logic [0:PPN_W-1] pageADDR,
    output logic             sweepBUSY
);

    // Entry layout: {spare, valid, writeable, cacheable, user, ppn}
    localparam int ENTRY_W  = PPN_W + 5;
    localparam int E_VALID  = PPN_W + 3;
    localparam int E_WRITE  = PPN_W + 2;
    localparam int E_CACHE  = PPN_W + 1;
    localparam int E_USER   = PPN_W;

    sweep_state_t         state_q, state_d;
    logic [PAGE_AW-1:0]   cnt_q, cnt_d;
    logic                 paged_q, paged_d;
    logic [PPN_W-1:0]     vaddr_q, vaddr_d;

    logic [PAGE_AW-1:0]   page_idx;
    logic                 sweep_wr;
    logic                 host_wr;
    logic                 ram_we;
    logic [PAGE_AW-1:0]   ram_waddr;
    logic [ENTRY_W-1:0]   ram_wdata;
    logic [ENTRY_W-1:0]   host_entry;
    logic [ENTRY_W-1:0]   rd_entry;

    assign page_idx = vmaREG[VMA_PAGE_LSB-PAGE_AW+1:VMA_PAGE_LSB];

    always_comb begin
        host_entry                = '0;
        host_entry[E_VALID]       = dp[DP_VALID];
        host_entry[E_WRITE]       = dp[DP_WRITEABLE];
        host_entry[E_CACHE]       = dp[DP_CACHEABLE];
        host_entry[E_USER]        = dp[DP_USER];
        host_entry[PPN_W-1:0]     = dp[DP_LSB-PPN_W+1:DP_LSB];
    end

    // A sweep request in the same cycle as a page write wins; the write is
    // dropped. Nothing is written while reset is asserted.
    assign sweep_wr  = clken && (state_q == ST_SWEEP);
    assign host_wr   = clken && pageWRITE && !pageSWEEP && (state_q == ST_IDLE);
    assign ram_we    = rst && (sweep_wr || host_wr);
    assign ram_waddr = sweep_wr ? cnt_q : page_idx;
    assign ram_wdata = sweep_wr ? '0 : host_entry;

    pager_tlb_ram #(
        .AW (PAGE_AW),
        .DW (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (clken),
        .raddr (page_idx),
        .rdata (rd_entry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        paged_d = paged_q;
        vaddr_d = vaddr_q;
        if (clken) begin
            paged_d = pageENABLE && !vmaREG[VMA_PHYS];
            vaddr_d = vmaREG[VMA_PAGE_LSB-PPN_W+1:VMA_PAGE_LSB];
            case (state_q)
                ST_IDLE: begin
                    if (pageSWEEP) begin
                        state_d = ST_SWEEP;
                        cnt_d   = '0;
                    end
                end
                ST_SWEEP: begin
                    if (pageSWEEP) begin
                        cnt_d = '0;
                    end else begin
                        // Last index written this cycle; counter wraps to 0.
                        if (&cnt_q) begin
                            state_d = ST_IDLE;
                        end
                        cnt_d = cnt_q + PAGE_AW'(1);
                    end
                end
                default: begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // paged_q resets to 1 so the cleared read register shows as all-zero
    // flags and address straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            paged_q <= 1'b1;
            vaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            paged_q <= paged_d;
            vaddr_q <= vaddr_d;
        end
    end

    assign sweepBUSY = (state_q == ST_SWEEP);

    always_comb begin
        pageFLAGS = FLAGS_UNPAGED;
        pageADDR  = vaddr_q;
        if (paged_q) begin
            pageFLAGS[FLAG_VALID]     = rd_entry[E_VALID] && !sweepBUSY;
            pageFLAGS[FLAG_WRITEABLE] = rd_entry[E_WRITE];
            pageFLAGS[FLAG_CACHEABLE] = rd_entry[E_CACHE];
            pageFLAGS[FLAG_USER]      = rd_entry[E_USER];
            pageADDR                  = rd_entry[PPN_W-1:0];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{dp, vmaREG, rd_entry[ENTRY_W-1]};

endmodule

// File: tb/tb_pager_tlb.sv
module tb_pager_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic [0:35] dp;
    logic [0:35] vmaREG;
    logic        pageENABLE;
    logic        pageWRITE;
    logic        pageSWEEP;
    logic [0:3]  pageFLAGS;
    logic [0:10] pageADDR;
    logic        sweepBUSY;

    int nvec = 0;
    int nerr = 0;

    pager_tlb dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .dp         (dp),
        .vmaREG     (vmaREG),
        .pageENABLE (pageENABLE),
        .pageWRITE  (pageWRITE),
        .pageSWEEP  (pageSWEEP),
        .pageFLAGS  (pageFLAGS),
        .pageADDR   (pageADDR),
        .sweepBUSY  (sweepBUSY)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        bit        v;
        bit        w;
        bit        c;
        bit        u;
        bit [10:0] ppn;
    } ent_t;

    ent_t       m_mem [512];
    bit         m_sweeping;
    int         m_pos;
    logic [0:3] m_flags;
    logic [10:0] m_addr;
    logic       m_busy;

    // Applies one clock edge: the sweep clears its current entry, a page
    // write lands if allowed, then the looked-up entry is read (new data).
    task automatic model_step();
        int   idx;
        bit   do_wr;
        ent_t e;
        if (!clken) return;
        idx   = int'(vmaREG[18:26]);
        do_wr = pageWRITE && !m_sweeping && !pageSWEEP;
        if (m_sweeping) m_mem[m_pos] = '0;
        if (pageSWEEP) begin
            m_sweeping = 1'b1;
            m_pos      = 0;
        end else if (m_sweeping) begin
            m_pos = m_pos + 1;
            if (m_pos == 512) begin
                m_sweeping = 1'b0;
                m_pos      = 0;
            end
        end
        if (do_wr) begin
            e.v   = dp[18];
            e.w   = dp[21];
            e.c   = dp[22];
            e.u   = dp[23];
            e.ppn = dp[25:35];
            m_mem[idx] = e;
        end
        e = m_mem[idx];
        if (pageENABLE && !vmaREG[8]) begin
            m_flags = {e.v && !m_sweeping, e.w, e.c, e.u};
            m_addr  = e.ppn;
        end else begin
            m_flags = 4'b1100;
            m_addr  = vmaREG[16:26];
        end
        m_busy = m_sweeping;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [0:35] mk_vma(input bit phys, input logic [10:0] a);
        logic [0:35] v;
        v        = '0;
        v[8]     = phys;
        v[16:26] = a;
        return v;
    endfunction

    function automatic logic [0:35] mk_dp(input bit v, input bit w, input bit c,
                                         input bit u, input logic [10:0] ppn);
        logic [0:35] d;
        d        = '0;
        d[18]    = v;
        d[21]    = w;
        d[22]    = c;
        d[23]    = u;
        d[25:35] = ppn;
        return d;
    endfunction

    task automatic check_out(input string name, input logic [0:3] ef,
                             input logic [10:0] ea, input logic eb);
        nvec++;
        if (pageFLAGS !== ef || pageADDR !== ea || sweepBUSY !== eb) begin
            nerr++;
            $display("FAIL %s: got flags=%b addr=%o busy=%b, want flags=%b addr=%o busy=%b",
                     name, pageFLAGS, pageADDR, sweepBUSY, ef, ea, eb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic drive_cycle(input bit ck, input bit en, input logic [0:35] vma,
                               input logic [0:35] d, input bit wr, input bit sw);
        clken      = ck;
        pageENABLE = en;
        vmaREG     = vma;
        dp         = d;
        pageWRITE  = wr;
        pageSWEEP  = sw;
        @(posedge clk);
        model_step();
        #1;
        check_out("model", m_flags, m_addr, m_busy);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          ck;
        bit          en;
        logic [0:35] vma;
        logic [0:35] dp;
        bit          wr;
        bit          sw;
        logic [0:3]  flags;
        logic [10:0] addr;
        bit          busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_en;

        rst = 1'b0; clken = 1'b1; dp = '0; vmaREG = '0;
        pageENABLE = 1'b1; pageWRITE = 1'b0; pageSWEEP = 1'b0;

        // Reset: two cycles, then outputs zero and sweep busy.
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 4'b0000, 11'o0, 1'b1);

        // Release: sweep runs exactly 512 enabled cycles; valid stays low.
        rst = 1'b1;
        n = 0;
        while (n < 2000) begin
            vmaREG = mk_vma(1'b0, 11'($urandom_range(0, 2047)));
            @(posedge clk);
            #1;
            n++;
            check_int("reset_sweep_valid", int'(pageFLAGS[0]), 0);
            if (!sweepBUSY) break;
        end
        check_int("reset_sweep_len", n, 512);

        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        m_sweeping = 1'b0; m_pos = 0;
        m_flags = 4'b0000; m_addr = '0; m_busy = 1'b0;

        tbl[0]  = '{ck:1, en:1, vma:mk_vma(0, 11'o0123), dp:mk_dp(1,1,0,1,11'o1234), wr:1, sw:0,
                    flags:4'b1101, addr:11'o1234, busy:0};
        tbl[1]  = '{ck:1, en:1, vma:mk_vma(0, 11'o0123), dp:'0, wr:0, sw:0,
                    flags:4'b1101, addr:11'o1234, busy:0};
        tbl[2]  = '{ck:1, en:0, vma:mk_vma(0, 11'o0777), dp:'0, wr:0, sw:0,
                    flags:4'b1100, addr:11'o0777, busy:0};
        tbl[3]  = '{ck:1, en:1, vma:mk_vma(1, 11'o0777), dp:'0, wr:0, sw:0,
                    flags:4'b1100, addr:11'o0777, busy:0};
        tbl[4]  = '{ck:0, en:1, vma:mk_vma(0, 11'o0123), dp:'0, wr:0, sw:0,
                    flags:4'b1100, addr:11'o0777, busy:0};
        tbl[5]  = '{ck:1, en:1, vma:mk_vma(0, 11'o0007), dp:mk_dp(1,0,1,0,11'o0007), wr:1, sw:0,
                    flags:4'b1010, addr:11'o0007, busy:0};
        tbl[6]  = '{ck:1, en:1, vma:mk_vma(0, 11'o0005), dp:'0, wr:0, sw:0,
                    flags:4'b0000, addr:11'o0000, busy:0};
        tbl[7]  = '{ck:1, en:1, vma:mk_vma(1, 11'o3123), dp:'0, wr:0, sw:0,
                    flags:4'b1100, addr:11'o3123, busy:0};
        tbl[8]  = '{ck:1, en:1, vma:mk_vma(0, 11'o3123), dp:'0, wr:0, sw:0,
                    flags:4'b1101, addr:11'o1234, busy:0};
        tbl[9]  = '{ck:1, en:0, vma:mk_vma(0, 11'o0200), dp:mk_dp(1,1,1,1,11'o3777), wr:1, sw:0,
                    flags:4'b1100, addr:11'o0200, busy:0};
        tbl[10] = '{ck:1, en:1, vma:mk_vma(0, 11'o0200), dp:'0, wr:0, sw:0,
                    flags:4'b1111, addr:11'o3777, busy:0};

        for (int i = 0; i < 11; i++) begin
            drive_cycle(tbl[i].ck, tbl[i].en, tbl[i].vma, tbl[i].dp, tbl[i].wr, tbl[i].sw);
            check_out($sformatf("tbl%0d", i), tbl[i].flags, tbl[i].addr, tbl[i].busy);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [0:35] v;
            logic [0:35] d;
            v = {$urandom, 4'($urandom)};
            d = {$urandom, 4'($urandom)};
            v[8] = ($urandom_range(0, 4) == 0);
            v[16:26] = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                    : 11'($urandom_range(0, 15));
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, v, d,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 399) == 0);
        end
        n = 0;
        while (m_busy && n < 1000) begin
            drive_cycle(1, 1, mk_vma(0, 11'o0), '0, 0, 0);
            n++;
        end

        // Write during sweep is dropped.
        drive_cycle(1, 1, mk_vma(0, 11'o0005), mk_dp(1,1,1,1,11'o0055), 1, 0);
        check_int("pre_sweep_valid5", int'(pageFLAGS[0]), 1);
        drive_cycle(1, 1, mk_vma(0, 11'o0005), '0, 0, 1);
        for (int i = 0; i < 10; i++) drive_cycle(1, 1, mk_vma(0, 11'o0003), '0, 0, 0);
        drive_cycle(1, 1, mk_vma(0, 11'o0005), mk_dp(1,1,1,1,11'o0066), 1, 0);
        n = 0;
        while (sweepBUSY && n < 1000) begin
            drive_cycle(1, 1, mk_vma(0, 11'o0003), '0, 0, 0);
            n++;
        end
        check_int("sweep_finished", int'(sweepBUSY), 0);
        drive_cycle(1, 1, mk_vma(0, 11'o0005), '0, 0, 0);
        check_int("wr_during_sweep_valid", int'(pageFLAGS[0]), 0);

        // Sweep restart at count 300, with a 20-cycle clken freeze.
        drive_cycle(1, 1, mk_vma(0, 11'o0001), '0, 0, 1);
        for (int i = 0; i < 300; i++) drive_cycle(1, 1, mk_vma(0, 11'o0001), '0, 0, 0);
        drive_cycle(1, 1, mk_vma(0, 11'o0001), '0, 0, 1);
        n_en = 0;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1, 1, mk_vma(0, 11'o0002), '0, 0, 0);
            n_en++;
        end
        for (int i = 0; i < 20; i++) drive_cycle(0, 1, mk_vma(0, 11'o0004), '0, 0, 0);
        check_int("busy_after_freeze", int'(sweepBUSY), 1);
        n = 0;
        while (sweepBUSY && n < 1000) begin
            drive_cycle(1, 1, mk_vma(0, 11'o0002), '0, 0, 0);
            n_en++;
            n++;
        end
        check_int("restart_len", n_en, 512);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pager_tlb.md
Name: pager_tlb

Overview:
- Page-translation table sitting directly upstream of the page-fail/interrupt dispatch.
- Maps the virtual page in the VMA to a physical page.
- Produces the 4-bit page flags (valid, writeable, cacheable, user) that the dispatch logic consumes to detect invalid, mismatch and write-violation faults.
- Owns the sweep (invalidate-all) sequencer that the microcode starts after paging reconfiguration.

Parameters:
- PAGE_AW, 9, virtual page index width (vmaREG[18:26]); table depth 2**PAGE_AW.
- PPN_W, 11, physical page number width (physical address bits [16:26]).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- clken  in  1  CPU clock enable; all state advances only when 1.
- dp  in  36  datapath [0:35]; source of page-write data.
- vmaREG  in  36  VMA register [0:35]; vmaREG[18:26] is the page index; vmaPHYS/vmaUSER taken from the standard vma.vh fields.
- pageENABLE  in  1  APR paging-enable flag.
- pageWRITE  in  1  decoded microcode page-write strobe.
- pageSWEEP  in  1  decoded microcode sweep strobe.
- pageFLAGS  out  4  [0:3] = valid, writeable, cacheable, user.
- pageADDR  out  PPN_W  physical page number [16:26].
- sweepBUSY  out  1  sweep in progress.

Behaviour:
- Storage: 2**PAGE_AW entries of {valid, writeable, cacheable, user, ppn[PPN_W]}, one synchronous-read/synchronous-write RAM (16 bits wide).
- Write (clken & pageWRITE & !sweepBUSY):
  - entry[vmaREG[18:26]] <= {dp[18], dp[21], dp[22], dp[23], dp[25:35]}.
  - Write while sweepBUSY is ignored (no RAM write, no error).
- Lookup, 1 clken-cycle latency:
  - On each clken edge the RAM reads entry[vmaREG[18:26]].
  - pageFLAGS/pageADDR are registered and describe the vmaREG value present on the previous clken edge.
  - Read-during-write to the same index returns the NEW data (write-first).
- Address select (registered with lookup):
  - If pageENABLE & !vmaPHYS: pageADDR = entry.ppn.
  - Otherwise: pageADDR = vmaREG[16:26] and pageFLAGS = 4'b1100 (valid, writeable, not cacheable, not user). This prevents false faults when paging is off.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clken & pageSWEEP; sweep counter <= 0.
  - In SWEEP, each clken: entry[cnt] <= 0 (valid=0), then cnt <= cnt+1.
  - SWEEP -> IDLE after writing index 2**PAGE_AW-1. This is exactly 512 clken cycles for the default; the counter wraps to 0.
  - pageSWEEP during SWEEP restarts the counter at 0 (sweep extends).
  - sweepBUSY = (state == SWEEP).
  - While sweepBUSY, the pageFLAGS valid bit is forced 0 when paging applies. Downstream then sees "page not valid" rather than stale data.
  - clken=0 freezes the counter and FSM.
- Reset (rst==0 at clk edge):
  - state <= SWEEP, cnt <= 0, pageFLAGS <= 0, pageADDR <= 0. The table is therefore invalidated automatically after every reset.
  - sweepBUSY reads 1 immediately after reset.
  - Reset mid-sweep restarts the sweep from 0.
- Simultaneous events:
  - pageSWEEP and pageWRITE in the same cycle: the sweep wins and the write is dropped.
  - Lookup and sweep-write in the same cycle use one RAM port for write and one for read (simple dual-port).

Decomposition:
- Shared package/include (pager.vh): field positions for pageFLAGS (pageVALID, pageWRITEABLE, pageCACHEABLE, pageUSER), dp page-write bit positions, PAGE_AW/PPN_W defaults. The dispatch stage already uses the pageFLAGS accessors, so the same macros serve both blocks.
- One sub-module: pager_ram, a simple dual-port 16-bit x 2**PAGE_AW synchronous RAM with write-first bypass. FSM, counter and output muxing stay in pager_tlb.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then release with clken=1 -> sweepBUSY=1 for exactly 512 clken cycles then 0. Lookup of any index during and after the sweep gives pageFLAGS[0]=0 with pageENABLE=1.
- Write/lookup:
  - Stimulus: pageENABLE=1, vmaREG[18:26]=9'o123, dp[18]=1, dp[21]=1, dp[23]=1, dp[25:35]=11'o1234, pulse pageWRITE.
  - Then re-present the same VMA -> one clken later pageFLAGS=4'b1101, pageADDR=11'o1234.
- Paging off/physical: pageENABLE=0 (then pageENABLE=1 with vmaPHYS=1), vmaREG[16:26]=11'o0777 -> pageADDR=11'o0777, pageFLAGS=4'b1100 in both cases.
- Write during sweep: pulse pageSWEEP, then pageWRITE to index 5 at sweep count 10 -> after the sweep completes, index 5 reads valid=0.
- Sweep restart: pageSWEEP at count 300 -> sweepBUSY stays 1 for 512 further clken cycles. clken held 0 for 20 cycles mid-sweep -> the total still counts 512 enabled cycles.
- Write-first bypass: write index 7 while vmaREG indexes 7 in the same cycle -> next-cycle pageFLAGS/pageADDR show the newly written data.
